// File: rtl/dual_alu4_macro.sv
// Two independent 4-bit ALUs behind a two-stage pad pipeline (pad sample, then compute).
// Optional macro SIGNED_OVF_EN replaces the OP0 echo on io_out[9:8] with {V1, V0}.
module dual_alu4_macro (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic [37:0] io_in,
   output logic [37:0] io_out,
   output logic [37:0] io_oeb
);

   typedef struct packed {
      logic [3:0] r;
      logic       c;
      logic       z;
      logic       v;
   } alu_res_t;

   function automatic alu_res_t alu4(input logic [3:0] a, input logic [3:0] b,
                                     input logic [1:0] op);
      alu_res_t   res;
      logic [4:0] sum;
      res = '0;
      sum = '0;
      case (op)
         2'b00: begin
            sum   = {1'b0, a} + {1'b0, b};
            res.r = sum[3:0];
            res.c = sum[4];
            res.v = (a[3] == b[3]) && (res.r[3] != a[3]);
         end
         2'b01: begin
            // bit 4 of the widened difference is the borrow (A < B unsigned)
            sum   = {1'b0, a} - {1'b0, b};
            res.r = sum[3:0];
            res.c = sum[4];
            res.v = (a[3] != b[3]) && (res.r[3] != a[3]);
         end
         2'b10:   res.r = a & b;
         default: res.r = a ^ b;
      endcase
      res.z = (res.r == 4'd0);
      return res;
   endfunction

   logic [19:0] s1_q, s1_d;
   logic        s1_vld_q, s1_vld_d;
   logic [3:0]  r0_q, r0_d, r1_q, r1_d;
   logic [1:0]  mid_q, mid_d;
   logic        z0_q, z0_d, c0_q, c0_d, z1_q, z1_d, c1_q, c1_d;
   logic        vld_q, vld_d;
   alu_res_t    alu0, alu1;
   logic        unused_bits;

   assign s1_d     = io_in[37:18];
   assign s1_vld_d = 1'b1;

   // s1_q: [19:18]=OP1 [17:16]=OP0 [15:12]=B1 [11:8]=A1 [7:4]=B0 [3:0]=A0
   assign alu0 = alu4(s1_q[3:0],  s1_q[7:4],   s1_q[17:16]);
   assign alu1 = alu4(s1_q[11:8], s1_q[15:12], s1_q[19:18]);

   // Data is held at zero until stage 1 holds a real sample, so no stray Z flags show.
   always_comb begin
      r0_d  = '0;
      r1_d  = '0;
      mid_d = '0;
      z0_d  = 1'b0;
      c0_d  = 1'b0;
      z1_d  = 1'b0;
      c1_d  = 1'b0;
      vld_d = s1_vld_q;
      if (s1_vld_q) begin
         r0_d = alu0.r;
         r1_d = alu1.r;
         z0_d = alu0.z;
         c0_d = alu0.c;
         z1_d = alu1.z;
         c1_d = alu1.c;
`ifdef SIGNED_OVF_EN
         mid_d = {alu1.v, alu0.v};
`else
         mid_d = s1_q[17:16];
`endif
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         s1_q     <= '0;
         s1_vld_q <= 1'b0;
         r0_q     <= '0;
         r1_q     <= '0;
         mid_q    <= '0;
         z0_q     <= 1'b0;
         c0_q     <= 1'b0;
         z1_q     <= 1'b0;
         c1_q     <= 1'b0;
         vld_q    <= 1'b0;
      end else begin
         s1_q     <= s1_d;
         s1_vld_q <= s1_vld_d;
         r0_q     <= r0_d;
         r1_q     <= r1_d;
         mid_q    <= mid_d;
         z0_q     <= z0_d;
         c0_q     <= c0_d;
         z1_q     <= z1_d;
         c1_q     <= c1_d;
         vld_q    <= vld_d;
      end
   end

   assign io_out = {20'h0, r0_q, r1_q, mid_q, z1_q, c1_q, c0_q, z0_q, 3'b000, vld_q};
   assign io_oeb = {20'hFFFFF, 14'h0000, 3'b111, 1'b0};

   assign unused_bits = ^{io_in[17:0], alu0.v, alu1.v};

endmodule

// File: tb/tb_dual_alu4_macro.sv
// Scoreboard bench for dual_alu4_macro: directed vectors with hand-computed results,
// streamed one per cycle, with a mid-stream reset.
module tb_dual_alu4_macro;

   logic        clk;
   logic        rst;
   logic [37:0] io_in;
   logic [37:0] io_out;
   logic [37:0] io_oeb;

   typedef struct {
      logic [3:0] a0, b0, a1, b1;
      logic [1:0] op0, op1;
      logic [3:0] r0, r1;
      logic       c0, z0, c1, z1, v0, v1;
   } vec_t;

   vec_t        vecs[$];
   logic [37:0] sb[$];
   logic [37:0] oeb_exp;
   int          checks = 0;
   int          errors = 0;
   bit          chk_rst = 1'b0;
   bit          done = 1'b0;

   dual_alu4_macro dut (
      .wb_clk_i(clk),
      .wb_rst_i(rst),
      .io_in   (io_in),
      .io_out  (io_out),
      .io_oeb  (io_oeb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [37:0] exp_of(input vec_t t);
      logic [1:0] mid;
`ifdef SIGNED_OVF_EN
      mid = {t.v1, t.v0};
`else
      mid = t.op0;
`endif
      return {20'h0, t.r0, t.r1, mid, t.z1, t.c1, t.c0, t.z0, 3'b000, 1'b1};
   endfunction

   task automatic add_vec(input logic [3:0] a0, input logic [3:0] b0, input logic [1:0] op0,
                          input logic [3:0] a1, input logic [3:0] b1, input logic [1:0] op1,
                          input logic [3:0] r0, input logic c0, input logic z0,
                          input logic [3:0] r1, input logic c1, input logic z1,
                          input logic v0, input logic v1);
      vec_t t;
      t.a0 = a0; t.b0 = b0; t.op0 = op0; t.a1 = a1; t.b1 = b1; t.op1 = op1;
      t.r0 = r0; t.c0 = c0; t.z0 = z0; t.r1 = r1; t.c1 = c1; t.z1 = z1;
      t.v0 = v0; t.v1 = v1;
      vecs.push_back(t);
   endtask

   // Apply one vector for one edge; its result is expected two edges later.
   task automatic drive(input int idx);
      vec_t t;
      t = vecs[idx];
      io_in = {t.op1, t.op0, t.b1, t.a1, t.b0, t.a0, 18'h2A5A5};
      rst   = 1'b0;
      sb.push_back(exp_of(t));
      @(posedge clk);
      #1;
   endtask

   // Monitor: every check lives here; stimulus only raises flags and fills the queue.
   initial begin
      logic [37:0] exp;
      forever begin
         @(negedge clk);
         if (chk_rst) begin
            checks++;
            if (io_out !== 38'h0 || io_oeb !== oeb_exp) begin
               errors++;
               $display("FAIL reset_state io_out=%h io_oeb=%h want io_out=0 io_oeb=%h",
                        io_out, io_oeb, oeb_exp);
            end
         end else if (io_out[0] === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_valid io_out=%h with no result pending", io_out);
            end else begin
               exp = sb.pop_front();
               if (io_out !== exp) begin
                  errors++;
                  $display("FAIL result io_out=%h want %h", io_out, exp);
               end
            end
         end
         if (done) begin
            checks++;
            if (sb.size() != 0 || io_oeb !== oeb_exp) begin
               errors++;
               $display("FAIL drain pending=%0d io_oeb=%h want pending=0 io_oeb=%h",
                        sb.size(), io_oeb, oeb_exp);
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout simulation did not complete");
      $fatal(1);
   end

   initial begin
      oeb_exp = {20'hFFFFF, 14'h0000, 3'b111, 1'b0};
      //      a0    b0    op0    a1    b1    op1    r0    c0 z0  r1    c1 z1  v0 v1
      add_vec(4'h9, 4'h9, 2'b00, 4'h0, 4'h0, 2'b00, 4'h2, 1, 0, 4'h0, 0, 1, 1, 0);
      add_vec(4'h3, 4'h5, 2'b01, 4'hC, 4'hA, 2'b10, 4'hE, 1, 0, 4'h8, 0, 0, 0, 0);
      add_vec(4'h7, 4'h7, 2'b01, 4'hC, 4'hA, 2'b11, 4'h0, 0, 1, 4'h6, 0, 0, 0, 0);
      add_vec(4'hF, 4'h1, 2'b00, 4'h0, 4'h1, 2'b01, 4'h0, 1, 1, 4'hF, 1, 0, 0, 0);
      add_vec(4'h7, 4'h1, 2'b00, 4'h2, 4'h1, 2'b01, 4'h8, 0, 0, 4'h1, 0, 0, 1, 0);
      add_vec(4'h8, 4'h1, 2'b01, 4'h5, 4'h3, 2'b00, 4'h7, 0, 0, 4'h8, 0, 0, 1, 1);
      add_vec(4'h0, 4'h0, 2'b10, 4'hF, 4'hF, 2'b00, 4'h0, 0, 1, 4'hE, 1, 0, 0, 0);
      add_vec(4'h6, 4'h3, 2'b11, 4'h6, 4'h3, 2'b10, 4'h5, 0, 0, 4'h2, 0, 0, 0, 0);
      add_vec(4'hA, 4'h5, 2'b11, 4'h1, 4'h2, 2'b01, 4'hF, 0, 0, 4'hF, 1, 0, 0, 0);
      add_vec(4'h5, 4'hA, 2'b00, 4'h3, 4'h3, 2'b01, 4'hF, 0, 0, 4'h0, 0, 1, 0, 0);

      // Five-cycle power-on reset; outputs checked on the last four.
      rst   = 1'b1;
      io_in = '0;
      @(posedge clk);
      #1 chk_rst = 1'b1;
      repeat (4) @(posedge clk);
      #1 chk_rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) drive(i);

      // One-cycle reset mid-stream: the in-flight sample is dropped.
      rst = 1'b1;
      @(posedge clk);
      sb.delete();
      #1 chk_rst = 1'b1;
      @(negedge clk);
      #1 chk_rst = 1'b0;
      rst = 1'b0;

      for (int i = 9; i >= 4; i--) drive(i);

      // Let the last result emerge, then reset so nothing further is presented.
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 done = 1'b1;
   end

endmodule

// File: doc/dual_alu4_macro.md
DUAL_ALU4_MACRO -- requirements
Module: dual_alu4_macro

Interface
REQ-001 Parameters: none; all widths and the pin map are fixed.
REQ-002 wb_clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 wb_rst_i  input  1  reset, synchronous, active-high.
REQ-004 io_in  input  38  pad inputs: A0=io_in[21:18], B0=io_in[25:22], A1=io_in[29:26], B1=io_in[33:30], OP0=io_in[35:34], OP1=io_in[37:36].
REQ-005 io_out  output  38  pad outputs; only io_out[17:4] and io_out[0] carry data.
REQ-006 io_oeb  output  38  active-low output enable per pad.

Function
REQ-007 Two independent 4-bit ALUs: ALU0 (A0,B0,OP0) and ALU1 (A1,B1,OP1).
REQ-008 Opcodes: 00 = A+B, carry = carry-out; 01 = A-B, carry = borrow (1 when A<B unsigned); 10 = A AND B, carry = 0; 11 = A XOR B, carry = 0.
REQ-009 Result R = low 4 bits of the operation; zero flag Z = 1 iff R == 0.
REQ-010 Stage 1: io_in[37:18] registered every cycle.
REQ-011 Stage 2: ALU results, flags, echo bits and valid registered from stage-1 values.
REQ-012 Latency: io_in change sampled at edge n appears on io_out after edge n+1; throughput one operation per cycle; no handshake.
REQ-013 Output map: io_out[17:14]=R0, io_out[13:10]=R1, io_out[9:8]=OP0 echo, io_out[7]=Z1, io_out[6]=C1, io_out[5]=C0, io_out[4]=Z0, io_out[0]=VALID.
REQ-014 VALID = 0 in reset; becomes 1 at the second rising edge after wb_rst_i deasserts (stage 1 filled); stays 1 until the next reset.
REQ-015 io_out[3:1], io_out[37:18] and unused bits SHALL be driven 0.
REQ-016 io_oeb: 0 for bits [17:4] and [0]; 1 for bits [3:1] and [37:18].
REQ-017 Boundaries: 15+1 gives R=0000, C=1, Z=1; 0-1 gives R=1111, C=1; A=B under 01 gives R=0, C=0, Z=1.
REQ-018 Simultaneous changes on both ALUs' inputs SHALL be handled independently in the same cycle.

Reset
REQ-019 While wb_rst_i=1 at an edge: both pipeline stages cleared, all io_out bits 0, VALID=0.
REQ-020 Reset mid-operation discards in-flight data; after release, the first valid result reflects inputs sampled after release.
REQ-021 io_oeb is constant, independent of reset.

Configuration
REQ-022 Macro SIGNED_OVF_EN: when defined, io_out[8]=V0 and io_out[9]=V1.
REQ-023 Vn is two's-complement overflow of the op: add overflows when the operands have the same sign and R's sign differs; sub overflows when the operands have different signs and R's sign differs from A's; Vn = 0 for logic ops.
REQ-024 When SIGNED_OVF_EN is undefined, io_out[9:8] carries the OP0 echo per REQ-013.

Verification
REQ-025 Hold wb_rst_i=1 for 5 cycles -> io_out == 0, io_oeb bits [17:4],[0] = 0, others = 1.
REQ-026 A0=9, B0=9, A1=0, B1=0, OP0=OP1=00, macro undefined -> after 2 edges, {io_out[17:4],io_out[0]} = 15'b001000000010101 (R0=0010, C0=1, Z0=0, R1=0, Z1=1, VALID=1).
REQ-027 A0=3, B0=5, OP0=01 -> R0=1110, C0=1, Z0=0; A0=B0=7, OP0=01 -> R0=0, C0=0, Z0=1.
REQ-028 A1=C, B1=A: OP1=10 -> R1=1000, C1=0; OP1=11 -> R1=0110, C1=0.
REQ-029 Change inputs every cycle -> each result appears exactly 2 edges later; assert wb_rst_i for one cycle mid-stream -> outputs 0 the next cycle, VALID returns 2 edges after release.
REQ-030 SIGNED_OVF_EN defined: A0=7, B0=1, OP0=00 -> io_out[8]=1; A0=9, B0=9, OP0=00 -> io_out[8]=1; A1=2, B1=1, OP1=01 -> io_out[9]=0.
